// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg: shared op codes, mul/div FSM states and op-class helpers
package mips_cpu_bus_pkg;
   localparam logic [4:0] OP_DIVU  = 5'd4;
   localparam logic [4:0] OP_DIV   = 5'd5;
   localparam logic [4:0] OP_MULTU = 5'd7;
   localparam logic [4:0] OP_MULT  = 5'd8;
   localparam logic [4:0] OP_MTLO  = 5'd18;
   localparam logic [4:0] OP_MTHI  = 5'd19;

   typedef enum logic [1:0] {IDLE, RUN, FIX} muldiv_state_t;

   function automatic logic is_div_op(input logic [4:0] code);
      return code == OP_DIVU || code == OP_DIV;
   endfunction

   function automatic logic is_signed_op(input logic [4:0] code);
      return code == OP_DIV || code == OP_MULT;
   endfunction

   function automatic logic is_muldiv(input logic [4:0] code);
      return is_div_op(code) || code == OP_MULTU || code == OP_MULT;
   endfunction
endpackage

// File: rtl/mips_cpu_bus_muldiv_step.sv
// mips_cpu_bus_muldiv_step: one shift-add multiply or restoring shift-subtract divide step
module mips_cpu_bus_muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] upper,
   input  logic [WIDTH-1:0] lower,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] next_upper,
   output logic [WIDTH-1:0] next_lower
);
   logic [WIDTH:0] sum, shifted, trial;

   // mult: {upper,lower} is partial product over the remaining multiplier bits; div: {remainder,quotient}
   always_comb begin
      sum        = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
      shifted    = {upper, lower[WIDTH-1]};
      trial      = shifted - {1'b0, operand};
      next_upper = is_div ? (trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0]) : sum[WIDTH:1];
      next_lower = is_div ? {lower[WIDTH-2:0], ~trial[WIDTH]} : {sum[0], lower[WIDTH-1:1]};
   end
endmodule

// File: rtl/mips_cpu_bus_muldiv_sequencer.sv
// mips_cpu_bus_muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO over HI/LO.
// Define MIPS_MULDIV_FAST_MULT_EN for a single-cycle combinational multiply.
module mips_cpu_bus_muldiv_sequencer
   import mips_cpu_bus_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       control_alu,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   muldiv_state_t     state;
   logic [CW-1:0]     cnt;
   logic              is_div, sgn_a, sgn_b, zero_div;
   logic [WIDTH-1:0]  a_raw, upper, lower, operand;
   logic [WIDTH-1:0]  next_upper, next_lower;
   logic [WIDTH-1:0]  mag_a, mag_b, quo_fix, rem_fix, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic              sa, sb;

`ifdef MIPS_MULDIV_FAST_MULT_EN
   localparam bit FAST = 1'b1;
   assign prod = {{WIDTH{1'b0}}, lower} * {{WIDTH{1'b0}}, operand};
`else
   localparam bit FAST = 1'b0;
   assign prod = {upper, lower};
`endif

   mips_cpu_bus_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div(is_div),
      .upper(upper),
      .lower(lower),
      .operand(operand),
      .next_upper(next_upper),
      .next_lower(next_lower)
   );

   always_comb begin
      sa       = is_signed_op(control_alu) & op_a[WIDTH-1];
      sb       = is_signed_op(control_alu) & op_b[WIDTH-1];
      mag_a    = sa ? -op_a : op_a;
      mag_b    = sb ? -op_b : op_b;
      prod_fix = (sgn_a ^ sgn_b) ? -prod : prod;
      quo_fix  = (sgn_a ^ sgn_b) ? -lower : lower;
      rem_fix  = sgn_a ? -upper : upper;
      res_hi   = zero_div ? a_raw : is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = zero_div ? '1 : is_div ? quo_fix : prod_fix[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         is_div   <= 1'b0;
         sgn_a    <= 1'b0;
         sgn_b    <= 1'b0;
         zero_div <= 1'b0;
         a_raw    <= '0;
         upper    <= '0;
         lower    <= '0;
         operand  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (control_alu == OP_MTLO) lo <= op_a;
               else if (control_alu == OP_MTHI) hi <= op_a;
               else if (is_muldiv(control_alu)) begin
                  is_div   <= is_div_op(control_alu);
                  sgn_a    <= sa;
                  sgn_b    <= sb;
                  zero_div <= is_div_op(control_alu) && op_b == '0;
                  a_raw    <= op_a;
                  upper    <= '0;
                  lower    <= mag_a;
                  operand  <= mag_b;
                  cnt      <= CW'(WIDTH - 1);
                  busy     <= 1'b1;
                  // divide-by-zero and the fast multiplier go straight to the write-back
                  state    <= ((is_div_op(control_alu) && op_b == '0) ||
                               (FAST && !is_div_op(control_alu))) ? FIX : RUN;
               end
            end
            RUN: begin
               upper <= next_upper;
               lower <= next_lower;
               cnt   <= cnt - 1'b1;
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               hi    <= res_hi;
               lo    <= res_lo;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mips_cpu_bus_muldiv_sequencer.md
MIPS_CPU_BUS_MULDIV_SEQUENCER -- requirements
Module: mips_cpu_bus_muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand/HI/LO width (even, >=8).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 The block SHALL have port control_alu  input  5  op code: 4 DIVU, 5 DIV, 7 MULTU, 8 MULT, 18 MTLO, 19 MTHI.
REQ-006 The block SHALL have port op_a  input  WIDTH  rs value (dividend/multiplicand/MTxx source).
REQ-007 The block SHALL have port op_b  input  WIDTH  rt value (divisor/multiplier).
REQ-008 The block SHALL have port busy  output  1  high while an op is in flight; CPU stalls MFHI/MFLO/mul/div on it.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when HI/LO hold a new mul/div result.
REQ-010 The block SHALL have port hi  output  WIDTH  HI register.
REQ-011 The block SHALL have port lo  output  WIDTH  LO register.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, FIX; RUN iterates with a counter from WIDTH-1 down to 0.
REQ-013 In IDLE with start=1 and code 4/5/7/8, the block SHALL latch operand magnitudes (abs for 5/8) and signs, go to RUN, and raise busy at that edge (E0).
REQ-014 RUN SHALL execute one shift-add (mult) or restoring shift-subtract (div) step per cycle, for WIDTH steps (E1..EWIDTH), then go to FIX.
REQ-015 FIX SHALL apply sign correction (signed: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), write {hi,lo}, drop busy, pulse done, and return to IDLE at edge EWIDTH+1.
REQ-016 Result mapping: mult -> hi=upper WIDTH, lo=lower WIDTH of 2*WIDTH product; div -> lo=quotient, hi=remainder.
REQ-017 Divide by zero SHALL skip RUN: at E0 go to FIX; at E1 write lo=all-ones, hi=op_a, pulse done.
REQ-018 DIV of most-negative by -1 SHALL give lo=most-negative, hi=0 (wrap, no trap).
REQ-019 In IDLE with start=1 and code 18/19, MTLO/MTHI SHALL write op_a into lo/hi at that edge; busy and done stay 0.
REQ-020 start while busy SHALL be ignored with no effect on state, hi, lo.
REQ-021 start with any other code SHALL be ignored.
REQ-022 hi/lo SHALL hold their values except at FIX exit, MTxx write, or reset.
REQ-023 done SHALL be high for exactly one cycle per completed mul/div and never together with busy.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, aborting any op in flight; reset dominates start.

Configuration
REQ-025 With MIPS_MULDIV_FAST_MULT_EN defined, MULT/MULTU SHALL bypass RUN: product computed combinationally from latched operands, written in FIX at E1 (busy high one cycle, done pulse after E1).
REQ-026 Without MIPS_MULDIV_FAST_MULT_EN, MULT/MULTU SHALL use the iterative WIDTH-step path; DIV/DIVU are iterative in both builds.

Structure
REQ-027 The op codes (4,5,7,8,18,19) and the FSM state enum SHALL be defined in shared package mips_cpu_bus_pkg, also used by the ALU control decoder.
REQ-028 The per-step shift-add/shift-subtract arithmetic SHALL be a sub-module mips_cpu_bus_muldiv_step; sequencing, sign handling and HI/LO stay in this block.

Verification
REQ-029 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at E33 (iterative), hi=0xFFFFFFFE lo=0x00000001; at E1 with fast-mult macro.
REQ-030 MULT a=-7 b=3 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-031 DIVU a=100 b=0 -> done at E1, lo=0xFFFFFFFF hi=100; DIV a=0x80000000 b=-1 -> lo=0x80000000 hi=0.
REQ-032 MTHI a=0x12345678 then MTLO a=0xCAFEF00D -> hi/lo updated next edge, busy and done never asserted.
REQ-033 Start DIVU 50/7, reassert start with MULTU at E5, then reset at E10 -> second start ignored; after reset hi=lo=0, busy=0, no done pulse.
REQ-034 Back-to-back: new start in cycle after done -> accepted; done pulses count equals ops issued.
